// File: rtl/exp_add_sat_pipe_if.sv
// Handshake bundle for the exponent adder pipeline.
//
// Valid/ready semantics, identical on both sides: a transfer happens on a
// rising clk edge where valid and ready are both high. Once the producer
// raises valid, it holds valid and its payload stable until that transfer.
// Ready may depend combinationally on the consumer's state, but never on the
// valid of the same side.
interface exp_add_sat_pipe_if #(
  parameter int P = 8,
  parameter int W = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] Y;
  logic         ovf;
  logic         zero;

  // The pipeline itself.
  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Y, ovf, zero
  );

  // The surrounding datapath that feeds operands and drains results.
  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Y, ovf, zero
  );
endinterface

// File: rtl/exp_add_sat_pipe.sv
// Two-stage exponent adder: Y = A + zero_extend(B).
// Stage 1 captures the operands, stage 2 holds the sum and flags. A sum that
// reaches the reserved all-ones exponent (Inf/NaN code) raises ovf; with
// SAT=1 the result is clamped to all-ones, otherwise it wraps modulo 2^P.
// The two valid bits are the only control state.
module exp_add_sat_pipe #(
  parameter int P   = 8,
  parameter int W   = 5,
  parameter bit SAT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  exp_add_sat_pipe_if.slave bus
);

  // The adjustment is zero-extended into the exponent; it may not be wider.
  if (W > P) begin : g_width_check
    $error("exp_add_sat_pipe: W must not exceed P");
  end

  localparam logic [P-1:0] ALL_ONES = '1;
  localparam logic [P:0]   OVF_THR  = {1'b0, ALL_ONES};

  // Stage 1 registers
  logic         v1_q, v1_d;
  logic [P-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;

  // Stage 2 registers
  logic         v2_q, v2_d;
  logic [P-1:0] y_q, y_d;
  logic         ovf_q, ovf_d;
  logic         zero_q, zero_d;

  // Handshake control
  logic en1, en2, in_fire;

  // Arithmetic on stage 1 contents
  logic [P:0]   sum;
  logic         ovf_c;
  logic [P-1:0] y_c;
  logic         zero_c;

  // Stage enables: a stage may advance when it is empty or its successor moves.
  always_comb begin
    en2     = !v2_q | bus.out_ready;
    en1     = !v1_q | en2;
    in_fire = bus.in_valid & en1 & !rst;
  end

  // Add in P+1 bits so the carry out of the top exponent bit is never lost.
  always_comb begin
    sum    = {1'b0, a_q} + (P+1)'(b_q);
    ovf_c  = (sum >= OVF_THR);
    y_c    = (ovf_c && SAT) ? ALL_ONES : sum[P-1:0];
    zero_c = (y_c == '0);
  end

  // Stage 1 next state: capture operands only on an accepted input; a bubble
  // is inserted when the stage advances without a new input.
  always_comb begin
    v1_d = v1_q;
    a_d  = a_q;
    b_d  = b_q;
    if (en1) begin
      v1_d = in_fire;
    end
    if (in_fire) begin
      a_d = bus.A;
      b_d = bus.B;
    end
  end

  // Stage 2 next state: the payload only changes when real data arrives, so
  // Y/ovf/zero keep their last value across bubbles and stay zero after reset.
  always_comb begin
    v2_d   = v2_q;
    y_d    = y_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        y_d    = y_c;
        ovf_d  = ovf_c;
        zero_d = zero_c;
      end
    end
  end

  // Stage 1 register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      v1_q <= v1_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  // Stage 2 register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q   <= 1'b0;
      y_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v2_q   <= v2_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  // Outputs: ready is withheld for as long as reset is asserted.
  assign bus.in_ready  = en1 & !rst;
  assign bus.out_valid = v2_q;
  assign bus.Y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: doc/exp_add_sat_pipe.md
Name: exp_add_sat_pipe

Overview:
- Pipelined exponent adder for the floating-point datapath: Y = A + B, with A a P-bit biased exponent and B a W-bit unsigned adjustment (normalisation left-count or scale step).
- Opposite direction of the existing exponent subtractor. The natural-log and normalisation paths use it when an exponent must grow rather than shrink.
- Two-stage registered pipeline with valid/ready handshakes on both sides.
- Detects exponent overflow into the reserved all-ones (Inf/NaN) code.

Parameters:
P, 8, exponent width (8 for single precision, 11 for double)
W, 5, adjustment width; W <= P required
SAT, 1, 1 = saturate result to all-ones on overflow; 0 = wrap modulo 2^P

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  A/B valid this cycle
in_ready  output  1  block can accept A/B this cycle
A  input  P  biased exponent operand
B  input  W  unsigned adjustment, zero-extended to P
out_valid  output  1  Y/flags valid
out_ready  input  1  downstream accepts Y this cycle
Y  output  P  result exponent
ovf  output  1  result reached or exceeded 2^P-1
zero  output  1  Y == 0

Behaviour:
- Reset: asynchronous and active-high. It clears all stage registers and valid bits immediately, without waiting for a clock edge.
  - Outputs while rst is high and after release: out_valid=0, Y=0, ovf=0, zero=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after release.
- Stage 1 (S1): registers A, B and valid bit v1.
- Stage 2 (S2): registers Y, ovf, zero and valid bit v2. out_valid = v2.
- Enables:
  - en2 = !v2 | out_ready
  - en1 = !v1 | en2
  - in_ready = en1 & !rst
- Input transfer: when in_valid & in_ready.
  - S1 loads A/B and v1 <= 1.
  - If en1 and no input transfer occurs, v1 <= 0.
- S1 to S2 transfer: on en2.
  - S2 loads the computed result and v2 <= v1.
- Output transfer: when out_valid & out_ready.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid when no stall.
  - Throughput 1 result/cycle.
  - Simultaneous input, advance and output transfers in the same cycle are legal and must not lose or duplicate data.
- Arithmetic, performed in S2 on S1 contents:
  - sum = {1'b0, A} + zero-extended B, width P+1.
  - If sum >= 2^P-1: ovf=1. Y = all-ones when SAT=1; Y = sum[P-1:0] when SAT=0.
  - Otherwise: ovf=0, Y = sum[P-1:0].
  - zero = (Y == 0). Note SAT=0 wrap can yield zero=1 together with ovf=1.
- Stall behaviour:
  - While out_valid & !out_ready, Y, ovf and zero are held stable.
  - Once in_valid is asserted, A/B must stay stable until the input transfer; the block samples them only at the transfer.
  - With both stages full and out_ready=0, in_ready=0 in that cycle.
- Boundary cases:
  - A = 2^P-2, B = 1 gives exactly all-ones: flagged as overflow.
  - A=0, B=0 gives Y=0, zero=1.
  - B = 2^W-1 with A = 2^P-1 gives the maximum sum. P+1 bits must not truncate the carry.
- Reset mid-operation: in-flight data is discarded and never emitted after release.
- No other state; no FSM beyond the two valid bits.

Test Plan:
- P=8, W=5, SAT=1, out_ready=1; send A=8'h7F, B=5 → 2 cycles later out_valid=1, Y=8'h84, ovf=0, zero=0.
- Overflow edge, SAT=1:
  - A=8'hFA, B=4 → Y=8'hFE, ovf=0.
  - A=8'hFA, B=5 → Y=8'hFF, ovf=1.
  - A=8'hF0, B=31 → Y=8'hFF, ovf=1.
- SAT=0 wrap:
  - A=8'hF0, B=31 → Y=8'h0F, ovf=1.
  - A=8'hFF, B=1 → Y=8'h00, ovf=1, zero=1.
  - A=0, B=0 → Y=0, ovf=0, zero=1.
- Backpressure:
  - Hold out_ready=0 and offer 3 back-to-back inputs (1+1, 2+2, 3+3) → first two accepted, in_ready=0 on the third.
  - Y holds 8'h02.
  - Raise out_ready → outputs 8'h02, 8'h04, 8'h06 in order, no loss or duplication.
- Throughput: out_ready=1, 8 consecutive inputs A=i, B=i (i=0..7) → 8 consecutive out_valid cycles, Y=2i, starting 2 cycles after first accept.
- Reset mid-flight: both stages valid, assert rst asynchronously between clock edges → out_valid=0 and Y=0 immediately. After release, no stale result appears and in_ready=1.
